// File: rtl/mem_port_arbiter.sv
// ==== mem_port_arbiter: fetch/data arbiter onto one shared memory port | rev 1.0 ====
`default_nettype none

module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic        if_resp_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic        d_resp_valid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] C_MAX_STREAK = 4'(MAX_D_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_rv_q, if_rv_d;
  logic        d_rv_q, d_rv_d;

  logic w_if_grant;
  logic w_d_grant;
  logic w_busy;

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_rv_d    = 1'b0;
    d_rv_d     = 1'b0;
    w_if_grant = 1'b0;
    w_d_grant  = 1'b0;
    w_busy     = 1'b0;

    case (state_q)
      IDLE: begin
        // Data side wins unless it has already starved a waiting fetch long enough.
        if (d_req && !(if_req && (streak_q >= C_MAX_STREAK))) begin
          w_d_grant = 1'b1;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          we_d      = d_we;
          state_d   = BUSY_D;
          if (!if_req) begin
            streak_d = 4'd0;
          end else if (streak_q < C_MAX_STREAK) begin
            streak_d = 4'(streak_q + 4'd1);
          end
        end else if (if_req) begin
          w_if_grant = 1'b1;
          addr_d     = if_addr;
          we_d       = 1'b0;
          streak_d   = 4'd0;
          state_d    = BUSY_IF;
        end
      end
      BUSY_IF: begin
        w_busy = 1'b1;
        if (mem_ack) begin
          if_rdata_d = mem_rdata;
          if_rv_d    = 1'b1;
          state_d    = IDLE;
        end
      end
      BUSY_D: begin
        w_busy = 1'b1;
        if (mem_ack) begin
          d_rdata_d = we_q ? 32'd0 : mem_rdata;
          d_rv_d    = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      streak_q   <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
      if_rv_q    <= 1'b0;
      d_rv_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_rv_q    <= if_rv_d;
      d_rv_q     <= d_rv_d;
    end
  end

  // Strobes are gated by reset so nothing leaks out while reset is held.
  assign if_ready      = w_if_grant & ~reset;
  assign d_ready       = w_d_grant & ~reset;
  assign mem_req       = w_busy & ~reset;
  assign mem_we        = w_busy & we_q & ~reset;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign if_resp_valid = if_rv_q;
  assign if_rdata      = if_rdata_q;
  assign d_resp_valid  = d_rv_q;
  assign d_rdata       = d_rdata_q;

endmodule

`default_nettype wire
